// File: rtl/footsies_pkg.sv
// Shared definitions for the footsies character logic: reaction state encoding,
// default frame timings and damage values.
package footsies_pkg;

  typedef enum logic [2:0] {
    RS_ACTIVE    = 3'd0,
    RS_HITSTUN   = 3'd1,
    RS_BLOCKSTUN = 3'd2,
    RS_INVULN    = 3'd3,
    RS_KO        = 3'd4
  } react_state_t;

  localparam int HITSTUN_FRAMES_DEF   = 20;
  localparam int BLOCKSTUN_FRAMES_DEF = 12;
  localparam int INVULN_FRAMES_DEF    = 8;
  localparam int MAX_HEALTH_DEF       = 3;
  localparam int DMG_NORMAL_DEF       = 1;
  localparam int DMG_DIR_DEF          = 2;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/frame_countdown.sv
// Loadable frame down-counter; done flags the tick that finishes the count.
module frame_countdown #(
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          tick,
  output logic [CW-1:0] count,
  output logic          done
);

  assign done = tick && (count == CW'(1));

  // A load in the same cycle as a tick takes the full value; that tick is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (tick && (count != '0)) begin
      count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/hit_reaction_fsm.sv
// Target-side hit/block responder: turns collision verdicts into stun timing,
// invulnerability, damage and KO, and feeds blocking/hurtbox state back.
module hit_reaction_fsm
  import footsies_pkg::*;
#(
  parameter int HITSTUN_FRAMES   = HITSTUN_FRAMES_DEF,
  parameter int BLOCKSTUN_FRAMES = BLOCKSTUN_FRAMES_DEF,
  parameter int INVULN_FRAMES    = INVULN_FRAMES_DEF,
  parameter int MAX_HEALTH       = MAX_HEALTH_DEF,
  parameter int DMG_NORMAL       = DMG_NORMAL_DEF,
  parameter int DMG_DIR          = DMG_DIR_DEF,
  parameter int HW               = $clog2(MAX_HEALTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          frame_tick,
  input  logic          got_hit_target,
  input  logic          got_blocked_target,
  input  logic          attacker_diratk_flag,
  input  logic          back_held,
  input  logic          self_attacking,
  input  logic          round_reset,
  output logic          target_is_blocking,
  output logic          target_hurtbox_active,
  output logic [HW-1:0] health,
  output logic          in_hitstun,
  output logic          in_blockstun,
  output logic          ko,
  output logic          hit_pulse,
  output logic          block_pulse
);

  localparam int CW = $clog2(max3(HITSTUN_FRAMES, BLOCKSTUN_FRAMES, INVULN_FRAMES) + 1);

  function automatic logic [HW-1:0] sat_sub(input logic [HW-1:0] h, input int d);
    if (d >= int'(h)) return '0;
    return h - HW'(d);
  endfunction

  react_state_t  state;
  logic [CW-1:0] cnt_count;
  logic [CW-1:0] cnt_val;
  logic          cnt_load;
  logic          cnt_done;
  logic [HW-1:0] health_hit;

  assign health_hit = sat_sub(health, attacker_diratk_flag ? DMG_DIR : DMG_NORMAL);

  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = CW'(HITSTUN_FRAMES);
    if (state == RS_ACTIVE && got_hit_target) begin
      cnt_load = (health_hit != '0);
      cnt_val  = CW'(HITSTUN_FRAMES);
    end else if (state == RS_ACTIVE && got_blocked_target) begin
      cnt_load = 1'b1;
      cnt_val  = CW'(BLOCKSTUN_FRAMES);
    end else if (state == RS_HITSTUN && cnt_done) begin
      cnt_load = 1'b1;
      cnt_val  = CW'(INVULN_FRAMES);
    end
  end

  frame_countdown #(.CW(CW)) u_countdown (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (round_reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .tick     (frame_tick),
    .count    (cnt_count),
    .done     (cnt_done)
  );

  always_ff @(posedge clk) begin
    if (!rst_n || round_reset) begin
      state       <= RS_ACTIVE;
      health      <= HW'(MAX_HEALTH);
      hit_pulse   <= 1'b0;
      block_pulse <= 1'b0;
    end else begin
      hit_pulse   <= 1'b0;
      block_pulse <= 1'b0;
      case (state)
        RS_ACTIVE: begin
          // Verdicts stay high for the whole overlap; only ACTIVE listens to them.
          if (got_hit_target) begin
            health    <= health_hit;
            hit_pulse <= 1'b1;
            state     <= (health_hit == '0) ? RS_KO : RS_HITSTUN;
          end else if (got_blocked_target) begin
            block_pulse <= 1'b1;
            state       <= RS_BLOCKSTUN;
          end
        end
        RS_HITSTUN:   if (cnt_done) state <= RS_INVULN;
        RS_BLOCKSTUN: if (cnt_done) state <= RS_ACTIVE;
        RS_INVULN:    if (cnt_done) state <= RS_ACTIVE;
        RS_KO:        state <= RS_KO;
        default:      state <= RS_ACTIVE;
      endcase
    end
  end

  assign in_hitstun            = (state == RS_HITSTUN);
  assign in_blockstun          = (state == RS_BLOCKSTUN);
  assign ko                    = (state == RS_KO);
  assign target_hurtbox_active = (state == RS_ACTIVE) || (state == RS_HITSTUN) ||
                                 (state == RS_BLOCKSTUN);
  // Unregistered on purpose: the collision checker must see a block on the overlap cycle.
  assign target_is_blocking    = (state == RS_BLOCKSTUN) ||
                                 ((state == RS_ACTIVE) && back_held && !self_attacking);

endmodule
